// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: per-channel sync/polarity/debounce with press,
// release and long-press pulses, plus a stretched reset driven by one channel.

module key_conditioner_lane #(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   LONG_CYCLES     = 50000000,
  parameter logic ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_PRE = HW'(LONG_CYCLES - 1);

  logic          s1, s2, raw;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;

  // sync flops reset to the idle polarity so reset exit never looks like a press
  assign raw = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= ACTIVE_LOW;
      s2     <= ACTIVE_LOW;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      hold   <= '0;
      long_p <= 1'b0;
    end else begin
      s1     <= key;
      s2     <= s1;
      press  <= 1'b0;
      rel    <= 1'b0;
      long_p <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= raw;
        cnt   <= '0;
        press <= raw;
        rel   <= ~raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // hold saturates at LONG_CYCLES so long_p fires once per press
      if (!level) begin
        hold <= '0;
      end else if (hold < LONG_MAX) begin
        hold   <= hold + 1'b1;
        long_p <= (hold == LONG_PRE);
      end
    end
  end
endmodule

module key_conditioner #(
  parameter int                  CHANNELS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 1000000,
  parameter int                  LONG_CYCLES     = 50000000,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = {CHANNELS{1'b1}},
  parameter int                  RST_CH          = 0,
  parameter int                  RST_HOLD        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_o,
  output logic                any_press_o,
  output logic                sys_rst_n_o
);
  localparam int SW = $clog2(RST_HOLD + 1);
  localparam logic [SW-1:0] HOLD_MAX = SW'(RST_HOLD);

  logic [SW-1:0] stretch;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    key_conditioner_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[g])
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .key   (key_i[g]),
      .level (level_o[g]),
      .press (press_o[g]),
      .rel   (release_o[g]),
      .long_p(long_o[g])
    );
  end

  assign any_press_o = |press_o;

  // any press of the reset key during the stretch restarts the full hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stretch     <= '0;
      sys_rst_n_o <= 1'b0;
    end else if (level_o[RST_CH]) begin
      stretch     <= '0;
      sys_rst_n_o <= 1'b0;
    end else if (stretch < HOLD_MAX) begin
      stretch     <= stretch + 1'b1;
      sys_rst_n_o <= 1'b0;
    end else begin
      sys_rst_n_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: table-driven event timing, hand-written corner
// sequences and randomized keys checked every edge against a window-based model.

module tb_key_conditioner;
  localparam int         CH   = 4;
  localparam int         DC   = 8;
  localparam int         LC   = 32;
  localparam int         RH   = 16;
  localparam logic [3:0] MASK = 4'b0001;
  localparam int         RC   = 0;
  localparam logic [3:0] IDLE = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_i;
  logic [3:0] level_o, press_o, release_o, long_o;
  logic       any_press_o, sys_rst_n_o;

  key_conditioner #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC),
    .ACTIVE_LOW_MASK(MASK), .RST_CH(RC), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .rst(rst), .key_i(key_i), .level_o(level_o), .press_o(press_o),
    .release_o(release_o), .long_o(long_o), .any_press_o(any_press_o),
    .sys_rst_n_o(sys_rst_n_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: raw seen by the debouncer is the normalised key two edges old;
  // level flips once the last DC raw samples all disagree with it
  logic [3:0] kq[$];
  logic [3:0] rawq[$];
  logic [3:0] m_level, m_press, m_rel, m_long;
  int         m_since[4];
  int         m_zr;
  logic       m_rstn;

  // event marks relative to the last clear_marks()
  int edge_no;
  int fp[4], fr[4], fl[4], np[4], nr[4], nl[4];
  int rise_edge, low_edge;
  bit seen_low;

  typedef struct {
    int ch;
    int hold;
    int exp_press;
    int exp_long;
    int exp_rel;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    kq.push_back(4'h0);
    kq.push_back(4'h0);
    rawq.delete();
    m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < 4; c++) m_since[c] = 0;
    m_zr   = 0;
    m_rstn = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] k);
    logic [3:0] raw, pre;
    bit         all_diff;
    pre = m_level;
    raw = kq.pop_front();
    kq.push_back(k ^ MASK);
    rawq.push_back(raw);
    if (rawq.size() > DC) void'(rawq.pop_front());
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < 4; c++) begin
      all_diff = (rawq.size() == DC);
      foreach (rawq[j]) if (rawq[j][c] == pre[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[c] = ~pre[c];
        if (!pre[c]) m_press[c] = 1'b1;
        else         m_rel[c]   = 1'b1;
      end
      if (pre[c]) begin
        m_since[c]++;
        if (m_since[c] == LC) m_long[c] = 1'b1;
      end else begin
        m_since[c] = 0;
      end
    end
    if (pre[RC]) m_zr = 0;
    else         m_zr++;
    m_rstn = (m_zr >= RH + 1);
  endtask

  task automatic clear_marks();
    edge_no = 0;
    for (int c = 0; c < 4; c++) begin
      fp[c] = 0; fr[c] = 0; fl[c] = 0; np[c] = 0; nr[c] = 0; nl[c] = 0;
    end
    rise_edge = 0; low_edge = 0; seen_low = 1'b0;
  endtask

  function automatic logic [31:0] dut_vec();
    return {14'd0, level_o, press_o, release_o, long_o, any_press_o, sys_rst_n_o};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {14'd0, m_level, m_press, m_rel, m_long, |m_press, m_rstn};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge(key_i);
    #1;
    check("edge_outputs", dut_vec(), exp_vec());
    edge_no++;
    for (int c = 0; c < 4; c++) begin
      if (press_o[c])   begin np[c]++; if (fp[c] == 0) fp[c] = edge_no; end
      if (release_o[c]) begin nr[c]++; if (fr[c] == 0) fr[c] = edge_no; end
      if (long_o[c])    begin nl[c]++; if (fl[c] == 0) fl[c] = edge_no; end
    end
    if (!sys_rst_n_o) begin
      if (!seen_low) low_edge = edge_no;
      seen_low = 1'b1;
    end else if (seen_low && rise_edge == 0) begin
      rise_edge = edge_no;
    end
  endtask

  task automatic async_reset_pulse(input int ticks);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs", dut_vec(), 32'd0);
    repeat (ticks) tick();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int others;
    int rem[4];

    tbl[0] = '{1, 60, 10, 42, 70};
    tbl[1] = '{3, 30, 10,  0, 40};
    tbl[2] = '{3, 32, 10, 42, 42};
    tbl[3] = '{3, 31, 10,  0, 41};
    tbl[4] = '{2,  8, 10,  0, 18};
    tbl[5] = '{2,  7,  0,  0,  0};
    tbl[6] = '{1,  5,  0,  0,  0};
    tbl[7] = '{0, 20, 10,  0, 30};

    // reset idle and reset-release stretch
    rst   = 1'b0;
    key_i = IDLE;
    model_reset();
    #1;
    check("reset_state", dut_vec(), 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    clear_marks();
    repeat (16) tick();
    check("rst_release_edge16", {31'd0, sys_rst_n_o}, 32'd0);
    tick();
    check("rst_release_edge17", {31'd0, sys_rst_n_o}, 32'd1);
    check("rst_release_no_press", {28'd0, press_o | level_o}, 32'd0);

    // table: press for hold cycles, then watch pulse timing
    for (int i = 0; i < 8; i++) begin
      clear_marks();
      key_i = IDLE ^ (4'b0001 << tbl[i].ch);
      repeat (tbl[i].hold) tick();
      key_i = IDLE;
      repeat (60) tick();
      check($sformatf("tbl%0d_press_edge", i),   fp[tbl[i].ch], tbl[i].exp_press);
      check($sformatf("tbl%0d_long_edge", i),    fl[tbl[i].ch], tbl[i].exp_long);
      check($sformatf("tbl%0d_release_edge", i), fr[tbl[i].ch], tbl[i].exp_rel);
      check($sformatf("tbl%0d_pulse_count", i),
            np[tbl[i].ch] + nr[tbl[i].ch] + nl[tbl[i].ch],
            (tbl[i].exp_press != 0) + (tbl[i].exp_rel != 0) + (tbl[i].exp_long != 0));
      others = 0;
      for (int c = 0; c < 4; c++)
        if (c != tbl[i].ch) others += np[c] + nr[c] + nl[c];
      check($sformatf("tbl%0d_other_channels", i), others, 0);
    end

    // bounce on ch2: 5 high / 1 low for 40 cycles, then held high
    clear_marks();
    for (int i = 0; i < 40; i++) begin
      key_i = IDLE | (((i % 6) != 5) ? 4'b0100 : 4'b0000);
      tick();
    end
    check("bounce_no_press", np[2], 0);
    repeat (30) tick();
    check("bounce_press_edge", fp[2], 46);
    check("bounce_press_count", np[2], 1);
    key_i = IDLE;
    repeat (20) tick();

    // reset channel: re-press during stretch restarts the hold
    repeat (30) tick();
    check("rstch_idle_high", {31'd0, sys_rst_n_o}, 32'd1);
    clear_marks();
    key_i = 4'b0000;
    repeat (20) tick();
    key_i = IDLE;
    repeat (10) tick();
    key_i = 4'b0000;
    repeat (15) tick();
    key_i = IDLE;
    repeat (40) tick();
    check("rstch_press_edge", fp[0], 10);
    check("rstch_rst_low_edge", low_edge, 11);
    check("rstch_first_release", fr[0], 30);
    check("rstch_press_count", np[0], 2);
    check("rstch_rst_rise_edge", rise_edge, 72);

    // async reset mid-count: ch3 held 20 past press, ch1 count at 5
    clear_marks();
    key_i = IDLE | 4'b1000;
    repeat (23) tick();
    key_i = IDLE | 4'b1010;
    repeat (7) tick();
    check("midcount_ch3_level", {31'd0, level_o[3]}, 32'd1);
    check("midcount_ch1_level", {31'd0, level_o[1]}, 32'd0);
    async_reset_pulse(3);
    clear_marks();
    repeat (50) tick();
    check("post_reset_ch1_press", fp[1], 10);
    check("post_reset_ch3_press", fp[3], 10);
    check("post_reset_ch3_long", fl[3], 42);
    check("post_reset_long_count", nl[3], 1);
    key_i = IDLE;
    repeat (40) tick();

    // randomized keys with mixed bounce and long holds, occasional reset
    for (int c = 0; c < 4; c++) rem[c] = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 4; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          key_i[c] = ~key_i[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 45) : $urandom_range(1, 9);
        end
      end
      tick();
      if ($urandom_range(0, 799) == 0) async_reset_pulse(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
